// File: rtl/neuron_layer_ctrl.sv
// Layer sequencer for the neuron MAC datapath: schedules ROM fetches, accumulator
// clear/enable strobes and the per-neuron output load for one layer pass.
module neuron_layer_ctrl #(
  parameter int n_inputs    = 16,
  parameter int n_neurons   = 4,
  parameter int addr_width  = 32,
  parameter int rom_latency = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  r_en,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width-1:0] x_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  out_load,
  output logic [((n_neurons > 1) ? $clog2(n_neurons) : 1)-1:0] out_idx,
  output logic                  layer_done
);

  localparam int IW = (n_inputs > 1) ? $clog2(n_inputs) : 1;
  localparam int NW = (n_neurons > 1) ? $clog2(n_neurons) : 1;
  localparam int DW = (rom_latency > 1) ? $clog2(rom_latency) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(n_inputs - 1);
  localparam logic [NW-1:0] N_LAST = NW'(n_neurons - 1);
  localparam logic [DW-1:0] D_LAST = DW'(rom_latency - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [NW-1:0]           neuron_reg, neuron_next;
  logic [IW-1:0]           i_reg, i_next;
  logic [DW-1:0]           drain_reg, drain_next;
  logic [addr_width-1:0]   addr_reg, addr_next;

  logic                    busy_reg, busy_next;
  logic                    r_en_reg, r_en_next;
  logic [addr_width-1:0]   w_addr_reg, w_addr_next;
  logic [addr_width-1:0]   x_addr_reg, x_addr_next;
  logic                    acc_clr_reg, acc_clr_next;
  logic                    out_load_reg, out_load_next;
  logic [NW-1:0]           out_idx_reg, out_idx_next;
  logic                    layer_done_reg, layer_done_next;
  logic [rom_latency-1:0]  acc_pipe_reg;

  // Next-state logic; addr tracks neuron*n_inputs+i as a running count so
  // no multiplier is needed and addresses stay contiguous across neurons.
  always_comb begin
    state_next  = state_reg;
    neuron_next = neuron_reg;
    i_next      = i_reg;
    drain_next  = drain_reg;
    addr_next   = addr_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next  = S_FETCH;
          neuron_next = '0;
          i_next      = '0;
          addr_next   = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_reg == I_LAST) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          i_next    = i_reg + IW'(1);
          addr_next = addr_reg + addr_width'(1);
        end
      end
      S_DRAIN: begin
        if (drain_reg == D_LAST) begin
          state_next = S_LOAD;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      S_LOAD: begin
        if (neuron_reg != N_LAST) begin
          state_next  = S_FETCH;
          neuron_next = neuron_reg + NW'(1);
          i_next      = '0;
          addr_next   = addr_reg + addr_width'(1);
        end else begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered
  // in the same cycle the state is entered.
  always_comb begin
    busy_next       = (state_next == S_FETCH) || (state_next == S_DRAIN) ||
                      (state_next == S_LOAD);
    r_en_next       = (state_next == S_FETCH);
    w_addr_next     = r_en_next ? addr_next : '0;
    x_addr_next     = r_en_next ? addr_width'(i_next) : '0;
    acc_clr_next    = r_en_next && (i_next == '0);
    out_load_next   = (state_next == S_LOAD);
    out_idx_next    = out_load_next ? neuron_next : '0;
    layer_done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      neuron_reg     <= '0;
      i_reg          <= '0;
      drain_reg      <= '0;
      addr_reg       <= '0;
      busy_reg       <= 1'b0;
      r_en_reg       <= 1'b0;
      w_addr_reg     <= '0;
      x_addr_reg     <= '0;
      acc_clr_reg    <= 1'b0;
      out_load_reg   <= 1'b0;
      out_idx_reg    <= '0;
      layer_done_reg <= 1'b0;
      acc_pipe_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      neuron_reg     <= neuron_next;
      i_reg          <= i_next;
      drain_reg      <= drain_next;
      addr_reg       <= addr_next;
      busy_reg       <= busy_next;
      r_en_reg       <= r_en_next;
      w_addr_reg     <= w_addr_next;
      x_addr_reg     <= x_addr_next;
      acc_clr_reg    <= acc_clr_next;
      out_load_reg   <= out_load_next;
      out_idx_reg    <= out_idx_next;
      layer_done_reg <= layer_done_next;
      // acc_en trails r_en by exactly rom_latency cycles
      for (int k = rom_latency - 1; k > 0; k--) begin
        acc_pipe_reg[k] <= acc_pipe_reg[k-1];
      end
      acc_pipe_reg[0] <= r_en_reg;
    end
  end

  assign busy       = busy_reg;
  assign r_en       = r_en_reg;
  assign w_addr     = w_addr_reg;
  assign x_addr     = x_addr_reg;
  assign acc_clr    = acc_clr_reg;
  assign acc_en     = acc_pipe_reg[rom_latency-1];
  assign out_load   = out_load_reg;
  assign out_idx    = out_idx_reg;
  assign layer_done = layer_done_reg;

endmodule
